// File: rtl/mem_dma.sv
// Byte-copy DMA engine: copies len bytes from src to dst through a single-port memory, three cycles per byte.
// Optional constant-fill mode is compiled in when MEM_DMA_FILL_EN is defined.
module mem_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
`ifdef MEM_DMA_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RWAIT,
        WRITE,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] src_r, src_n;
    logic [ADDR_W-1:0] dst_r, dst_n;
    logic [ADDR_W-1:0] idx, idx_n;
    logic [ADDR_W-1:0] rem, rem_n;
    logic [ADDR_W-1:0] idx_inc;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              we_n;
    logic              fill_r, fill_n;
    logic              fill_req;
    logic [DATA_W-1:0] fill_data;

`ifdef MEM_DMA_FILL_EN
    assign fill_req  = fill;
    assign fill_data = fill_value;
`else
    assign fill_req  = 1'b0;
    assign fill_data = '0;
`endif

    assign idx_inc = idx + ADDR_W'(1);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    always_comb begin
        state_n = state;
        src_n   = src_r;
        dst_n   = dst_r;
        idx_n   = idx;
        rem_n   = rem;
        fill_n  = fill_r;
        addr_n  = mem_address;
        wdata_n = mem_data_in;
        we_n    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    src_n  = src;
                    dst_n  = dst;
                    rem_n  = len;
                    idx_n  = '0;
                    fill_n = fill_req;
                    if (len == '0) begin
                        state_n = DONE;
                    end else if (fill_req) begin
                        state_n = WRITE;
                        addr_n  = dst;
                        wdata_n = fill_data;
                        we_n    = 1'b1;
                    end else begin
                        state_n = RADDR;
                        addr_n  = src;
                    end
                end
            end
            RADDR: state_n = RWAIT;
            RWAIT: begin
                // The memory registered mem[src+i] on the previous edge.
                state_n = WRITE;
                wdata_n = mem_data_out;
                addr_n  = dst_r + idx;
                we_n    = 1'b1;
            end
            WRITE: begin
                rem_n = rem - ADDR_W'(1);
                idx_n = idx_inc;
                if (rem == ADDR_W'(1)) begin
                    state_n = DONE;
                end else if (fill_r) begin
                    state_n = WRITE;
                    addr_n  = dst_r + idx_inc;
                    we_n    = 1'b1;
                end else begin
                    state_n = RADDR;
                    addr_n  = src_r + idx_inc;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            src_r            <= '0;
            dst_r            <= '0;
            idx              <= '0;
            rem              <= '0;
            fill_r           <= 1'b0;
            mem_address      <= '0;
            mem_data_in      <= '0;
            mem_write_enable <= 1'b0;
        end else begin
            state            <= state_n;
            src_r            <= src_n;
            dst_r            <= dst_n;
            idx              <= idx_n;
            rem              <= rem_n;
            fill_r           <= fill_n;
            mem_address      <= addr_n;
            mem_data_in      <= wdata_n;
            mem_write_enable <= we_n;
        end
    end

endmodule

// File: tb/tb_mem_dma.sv
// Directed bench for mem_dma: behavioural memory, golden byte-sequential model and a write scoreboard.
// Fill-mode steps are included when MEM_DMA_FILL_EN is defined.
module tb_mem_dma;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] src, dst, len;
    logic       busy, done;
    logic [7:0] mem_address, mem_data_in, mem_data_out;
    logic       mem_write_enable;
`ifdef MEM_DMA_FILL_EN
    logic       fill;
    logic [7:0] fill_value;
`endif

    logic [7:0]  mem  [256];
    logic [7:0]  gold [256];
    logic [15:0] sb_q [$];
    int          tests   = 0;
    int          fails   = 0;
    int          strobes = 0;

    mem_dma #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .src              (src),
        .dst              (dst),
        .len              (len),
`ifdef MEM_DMA_FILL_EN
        .fill             (fill),
        .fill_value       (fill_value),
`endif
        .busy             (busy),
        .done             (done),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_data_out <= mem[mem_address];
    always @(negedge clk) if (mem_write_enable === 1'b1) mem[mem_address] = mem_data_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) begin
            logic [15:0] exp;
            strobes++;
            exp = (sb_q.size() != 0) ? sb_q.pop_front() : 16'hxxxx;
            check("write", {16'h0, mem_address, mem_data_in}, {16'h0, exp});
        end
    end

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) n++;
        return n;
    endfunction

    task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                            input bit f, input logic [7:0] fv, input string tag);
        int cyc;
        int exp_lat;
        int s0;
        logic [7:0] a;
        logic [7:0] v;
        @(negedge clk);
        start = 1'b1;
        src   = s;
        dst   = d;
        len   = l;
`ifdef MEM_DMA_FILL_EN
        fill       = f;
        fill_value = fv;
`endif
        for (int i = 0; i < int'(l); i++) begin
            a = d + 8'(i);
            v = f ? fv : gold[8'(s + 8'(i))];
            gold[a] = v;
            sb_q.push_back({a, v});
        end
        s0 = strobes;
        @(posedge clk);
        #1;
        start = 1'b0;
        src   = 8'($urandom);
        dst   = 8'($urandom);
        len   = 8'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cyc = 1;
        while (done !== 1'b1 && cyc < 2000) begin
            start = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        exp_lat = (l == 0) ? 1 : (f ? int'(l) + 1 : 3 * int'(l) + 1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'h0, done}, 32'd0);
        check({tag, "_idle"}, {31'h0, busy}, 32'd0);
        check({tag, "_strobes"}, 32'(strobes - s0), 32'(l));
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        check({tag, "_mem"}, 32'(mem_diffs()), 32'd0);
    endtask

    initial begin
        int s0;
        rst_n = 1'b0;
        start = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
`ifdef MEM_DMA_FILL_EN
        fill       = 1'b0;
        fill_value = '0;
`endif
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'($urandom);
            gold[i] = mem[i];
        end
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
        mem[8'h20] = 8'h5A;
        for (int i = 0; i < 256; i++) gold[i] = mem[i];

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_outs", {15'h0, mem_write_enable, mem_address, mem_data_in}, 32'd0);
        rst_n = 1'b1;

        run_xfer(8'h10, 8'h80, 8'd4, 1'b0, 8'h00, "copy4");
        check("copy4_bytes", {mem[8'h80], mem[8'h81], mem[8'h82], mem[8'h83]}, 32'hAABBCCDD);
        run_xfer(8'h50, 8'h60, 8'd0, 1'b0, 8'h00, "len0");
        run_xfer(8'hFE, 8'h40, 8'd3, 1'b0, 8'h00, "wrap3");
        run_xfer(8'h20, 8'h21, 8'd3, 1'b0, 8'h00, "overlap");
        check("overlap_bytes", {8'h0, mem[8'h21], mem[8'h22], mem[8'h23]}, 32'h005A5A5A);

        // Abort a copy while its second byte is being written.
        @(negedge clk);
        start = 1'b1; src = 8'h30; dst = 8'h90; len = 8'd4;
        gold[8'h90] = gold[8'h30];
        sb_q.push_back({8'h90, gold[8'h30]});
        s0 = strobes;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("abort_in_write", {31'h0, mem_write_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_we", {31'h0, mem_write_enable}, 32'd0);
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_outs", {15'h0, mem_write_enable, mem_address, mem_data_in}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_done", {31'h0, done}, 32'd0);
        check("abort_strobes", 32'(strobes - s0), 32'd1);
        check("abort_mem", 32'(mem_diffs()), 32'd0);
        rst_n = 1'b1;

        run_xfer(8'h30, 8'h90, 8'd4, 1'b0, 8'h00, "after_rst");
        run_xfer(8'h05, 8'h85, 8'd255, 1'b0, 8'h00, "len255");
`ifdef MEM_DMA_FILL_EN
        run_xfer(8'h00, 8'hF0, 8'd16, 1'b1, 8'h00, "fill16");
        run_xfer(8'h12, 8'hA0, 8'd5, 1'b0, 8'h00, "copy_fill0");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 SHALL have parameter: ADDR_W, 8, memory address width; all address/length arithmetic is modulo 2^ADDR_W.
REQ-002 SHALL have parameter: DATA_W, 8, memory data width.
REQ-003 SHALL have ports, one per line, as follows:
- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- src  input  ADDR_W  first source address; latched on accepted start.
- dst  input  ADDR_W  first destination address; latched on accepted start.
- len  input  ADDR_W  byte count; latched on accepted start.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle completion pulse.
- mem_address  output  ADDR_W  address to memory.
- mem_data_in  output  DATA_W  write data to memory.
- mem_write_enable  output  1  memory write strobe.
- mem_data_out  input  DATA_W  read data from memory.
REQ-004 Memory contract: memory registers data_out = mem[address] on posedge clk; memory writes on negedge clk when write_enable is high.

Function
REQ-005 SHALL implement a copy engine: for i = 0..len-1, mem[dst+i] <= mem[src+i], ascending i, addresses wrapping modulo 2^ADDR_W.
REQ-006 SHALL use FSM states IDLE, RADDR, RWAIT, WRITE, DONE.
REQ-007 Transitions:
- IDLE->RADDR on start with len!=0.
- IDLE->DONE on start with len==0; no memory access occurs.
- RADDR->RWAIT unconditionally.
- RWAIT->WRITE unconditionally.
- WRITE->RADDR if bytes remain, else WRITE->DONE.
- DONE->IDLE unconditionally.
REQ-008 All memory-side outputs SHALL be registered.
REQ-009 In RADDR: mem_address=src+i, mem_write_enable=0.
REQ-010 In RWAIT: mem_address held; mem_data_out is valid this cycle.
REQ-011 On the RWAIT->WRITE edge: mem_data_in<=mem_data_out, mem_address<=dst+i, mem_write_enable<=1.
REQ-012 mem_write_enable SHALL be high only in WRITE, for exactly one cycle per byte.
REQ-013 Throughput SHALL be 3 cycles per byte; total start-to-done latency = 3*len+1 cycles.
REQ-014 busy SHALL be high in RADDR, RWAIT, WRITE and DONE, and low in IDLE.
REQ-015 done SHALL be high only in DONE.
REQ-016 start while not IDLE SHALL be ignored; src/dst/len changes after acceptance SHALL have no effect.
REQ-017 Overlapping regions SHALL follow strict byte-sequential semantics: dst=src+1 replicates mem[src] across the region.
REQ-018 len=2^ADDR_W-1 with wrap past address 2^ADDR_W-1 to 0 SHALL be legal.

Reset
REQ-019 rst_n low SHALL asynchronously force:
- state=IDLE
- busy=0, done=0
- mem_address=0, mem_data_in=0, mem_write_enable=0
- internal counters=0
REQ-020 Reset mid-transfer SHALL abort it; no further writes occur after rst_n falls, and no done pulse is issued for the aborted transfer.
REQ-021 After rst_n rises, the first start SHALL be accepted on the next posedge.

Configuration
REQ-022 Macro MEM_DMA_FILL_EN, when defined, SHALL add input fill (1) and input fill_value (DATA_W).
REQ-023 With MEM_DMA_FILL_EN defined, start with fill=1 SHALL go IDLE->WRITE directly, writing fill_value to dst..dst+len-1 at 1 cycle per byte, RADDR/RWAIT skipped; latency = len+1.
REQ-024 With MEM_DMA_FILL_EN defined, start with fill=0 SHALL behave as copy.
REQ-025 Without MEM_DMA_FILL_EN, the fill and fill_value ports SHALL be absent and only copy mode exists.

Verification
REQ-026 mem[0x10..0x13]=AA,BB,CC,DD; start src=0x10 dst=0x80 len=4 -> mem[0x80..0x83]=AA,BB,CC,DD; done 13 cycles after start; exactly 4 write strobes.
REQ-027 start len=0 -> done pulses next cycle; no write strobe; memory unchanged.
REQ-028 src=0xFE dst=0x40 len=3 -> mem[0x40..0x42]=mem[0xFE],mem[0xFF],mem[0x00].
REQ-029 mem[0x20]=5A; src=0x20 dst=0x21 len=3 -> mem[0x21..0x23]=5A,5A,5A.
REQ-030 rst_n low during 2nd byte of len=4 copy -> write_enable low immediately; only byte 0 written; busy=0; second start completes normally.
REQ-031 MEM_DMA_FILL_EN defined: fill=1 fill_value=0x00 dst=0xF0 len=16 -> mem[0xF0..0xFF]=00; done 17 cycles after start.
